muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide responder for the multicycle ARM datapath.
- Executes the MUL (ALUControl 4'b0100) and DIV (ALUControl 4'b0111) operations that the decode/ALU decoder selects.
- The main FSM asserts start and then waits on busy/done before writing Result.
- Sits beside the single-cycle ALU. Result feeds the ALUResult/ALUOut mux.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request from control; sampled only in IDLE
ALUControl  input  4  operation select: 4'b0100 = MUL, 4'b0111 = DIV, all others = no operation
SrcA  input  WIDTH  multiplicand / dividend, unsigned
SrcB  input  WIDTH  multiplier / divisor, unsigned
busy  output  1  high while an operation is in progress, including the DONE cycle
done  output  1  single-cycle pulse; Result is valid when done is high
Result  output  WIDTH  MUL: low WIDTH bits of the product; DIV: quotient
Remainder  output  WIDTH  DIV remainder; 0 after MUL
DivByZero  output  1  set with done when a DIV has SrcB==0; held until the next accepted start
Flags  output  2  {N,Z} of Result, registered with Result

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy=0, done=0, Result=0, Remainder=0, DivByZero=0, Flags=2'b01 (Z set, since Result=0); counter=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and ALUControl=MUL at edge E0: latch SrcA and SrcB; clear the accumulator; counter=WIDTH; go to MUL.
  - start=1 and ALUControl=DIV, SrcB!=0: latch operands; clear the partial remainder; counter=WIDTH; go to DIV.
  - start=1 and ALUControl=DIV, SrcB==0: go directly to DONE. Result={WIDTH{1'b1}}, Remainder=SrcA, DivByZero=1.
  - start=1 with any other ALUControl: ignored; stay in IDLE with no output change.
- MUL, one iteration per edge (shift-add, LSB first): if multiplier[0]==1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter -= 1. After the WIDTH-th iteration (edge E_WIDTH) go to DONE. Product is taken modulo 2^WIDTH and overflow is discarded.
- DIV, one iteration per edge (restoring, MSB first): rem = {rem[WIDTH-2:0], dividend[MSB]}; dividend <<= 1. If rem >= divisor: rem -= divisor and shift 1 into the quotient; otherwise shift 0. After WIDTH iterations go to DONE.
- DONE, entered at edge E_WIDTH (E0 for divide-by-zero):
  - Result, Remainder, Flags and DivByZero are updated on that entering edge.
  - done=1 and busy=1 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after the start edge E0 (33 for WIDTH=32). Divide-by-zero takes 1 edge.
- busy rises in the cycle after E0 and falls with the DONE→IDLE edge.
- Result, Remainder, Flags and DivByZero hold their values in IDLE until the next accepted start. The MUL/DIV result overwrites them at the DONE entry.
- Flags: N=Result[WIDTH-1]; Z=(Result==0).
- start while in MUL, DIV or DONE is ignored. No queuing: a start coincident with the DONE cycle is dropped, and control must re-issue it in IDLE.
- SrcA, SrcB and ALUControl may change after E0 without effect, because operands are latched at E0.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is produced.

Test Plan:
- MUL 7×6 (WIDTH=32): start at E0 → done high exactly 33 edges later; Result=42, Remainder=0, Flags=2'b00, DivByZero=0.
- MUL overflow 0xFFFFFFFF×2 → Result=0xFFFFFFFE, N=1, Z=0; Result still holds that value 5 cycles after done.
- DIV 100/7 → done after 33 edges; Result=14, Remainder=2. DIV 5/9 → Result=0, Remainder=5, Flags=2'b01.
- DIV 1234/0 → done on the cycle after E0; Result=0xFFFFFFFF, Remainder=1234, DivByZero=1. The next MUL 3×3 clears DivByZero and gives Result=9.
- Protocol:
  - start with ALUControl=4'b0000 → busy stays 0 and no done is produced.
  - A second start pulse issued 10 cycles into a MUL is ignored; exactly one done appears, for the first operation.
  - Operands changed after E0 do not alter Result.
- Reset mid-op: assert reset low 15 cycles into DIV 100/7 → busy=0, Result=0 immediately, with no done. After release, a new DIV 100/7 completes normally with Result=14.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit beside the ALU.
// Latency: WIDTH+1 edges from the accepted start to the done pulse; divide-by-zero in 1 edge.
// Backpressure: none; start is only sampled in IDLE, and a start arriving while busy is dropped.
//
// Ports: clk/reset (async active-low), start + ALUControl + SrcA/SrcB request,
//        busy/done status, Result/Remainder/Flags/DivByZero registered outputs.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic [1:0]       Flags
);

    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // a: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // b: multiplier (MUL) or divisor (DIV)
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [1:0]       flags_q, flags_d;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    always_comb begin
        mul_sum = acc_q + (b_q[0] ? a_q : '0);

        // The shifted partial remainder is kept one bit wider so divisors with
        // the MSB set still compare correctly; the difference always fits WIDTH bits.
        div_sh  = {acc_q, a_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        div_rem = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
        div_quo = {a_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start && (ALUControl == OP_MUL)) begin
                    a_d     = SrcA;
                    b_d     = SrcB;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    dbz_d   = 1'b0;
                    state_d = S_MUL;
                end else if (start && (ALUControl == OP_DIV)) begin
                    if (SrcB == '0) begin
                        result_d = '1;
                        rem_d    = SrcA;
                        dbz_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = SrcA;
                        b_d     = SrcB;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = mul_sum;
                    rem_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                a_d   = div_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = div_quo;
                    rem_d    = div_rem;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags are registered alongside Result, only when DONE is entered.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            flags_d = {result_d[WIDTH-1], (result_d == '0)};
        end else begin
            flags_d = flags_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            flags_q  <= 2'b01;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            flags_q  <= flags_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign Result    = result_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;
    assign Flags     = flags_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized MUL/DIV
// checked against an arithmetic reference model (*, /, %).
// Clock period 10; inputs change after edges, outputs sampled 1 time unit after posedge.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0111;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic [W-1:0] Remainder;
    logic         DivByZero;
    logic [1:0]   Flags;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .Remainder  (Remainder),
        .DivByZero  (DivByZero),
        .Flags      (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] rm, output logic dz,
                         output int lat);
        logic [63:0] prod;
        if (op == OP_MUL) begin
            prod = 64'(a) * 64'(b);
            r    = prod[W-1:0];
            rm   = '0;
            dz   = 1'b0;
            lat  = W + 1;
        end else if (b == 0) begin
            r   = '1;
            rm  = a;
            dz  = 1'b1;
            lat = 1;
        end else begin
            r   = a / b;
            rm  = a % b;
            dz  = 1'b0;
            lat = W + 1;
        end
    endtask

    // Drive a start pulse through edge E0; afterwards scramble the inputs.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        edges      = 1;
        start      = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        chk({tag, "_busy_e0"}, 64'(busy), 64'(1));
        while (done !== 1'b1 && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        chk({tag, "_busy_done"}, 64'(busy), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, erm;
        logic         edz;
        int           elat;
        model(op, a, b, er, erm, edz, elat);
        start_op(op, a, b);
        wait_done(tag, elat);
        chk({tag, "_result"}, 64'(Result), 64'(er));
        chk({tag, "_rem"}, 64'(Remainder), 64'(erm));
        chk({tag, "_dbz"}, 64'(DivByZero), 64'(edz));
        chk({tag, "_flags"}, 64'(Flags), 64'({er[W-1], er == 0}));
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_idle_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] keep;
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;
        int           n_done;
        int           n_busy;

        reset      = 1'b0;
        start      = 1'b0;
        ALUControl = 4'b0000;
        SrcA       = '0;
        SrcB       = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(Result), 64'(0));
        chk("rst_rem", 64'(Remainder), 64'(0));
        chk("rst_dbz", 64'(DivByZero), 64'(0));
        chk("rst_flags", 64'(Flags), 64'(2'b01));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6);
        run_op("mul_ovf", OP_MUL, 32'hFFFF_FFFF, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("mul_ovf_hold", 64'(Result), 64'(32'hFFFF_FFFE));
        chk("mul_ovf_hold_flags", 64'(Flags), 64'(2'b10));
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7);
        run_op("div_5_9", OP_DIV, 32'd5, 32'd9);
        run_op("div_by_0", OP_DIV, 32'd1234, 32'd0);
        run_op("mul_3x3", OP_MUL, 32'd3, 32'd3);
        run_op("div_big_divisor", OP_DIV, 32'hFFFF_FFF0, 32'h8000_0001);

        // Unsupported opcode: ignored entirely.
        keep = Result;
        start_op(4'b0000, 32'd9, 32'd9);
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) n_done++;
            @(posedge clk);
            #1;
        end
        chk("nop_busy_cycles", 64'(n_busy), 64'(0));
        chk("nop_done_count", 64'(n_done), 64'(0));
        chk("nop_result_held", 64'(Result), 64'(keep));

        // Second start 10 cycles into a MUL is dropped.
        start_op(OP_MUL, 32'd11, 32'd13);
        repeat (9) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start      = 1'b1;
        ALUControl = OP_MUL;
        SrcA       = 32'd2;
        SrcB       = 32'd2;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        wait_done("mul_restart", W + 1);
        chk("mul_restart_result", 64'(Result), 64'(143));
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        chk("mul_restart_extra_done", 64'(n_done), 64'(0));

        // Reset in the middle of a divide.
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_result", 64'(Result), 64'(0));
        chk("midrst_flags", 64'(Flags), 64'(2'b01));
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("div_after_rst", OP_DIV, 32'd100, 32'd7);

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = $urandom | 32'h8000_0000;
                2:       rb = 32'($urandom_range(1, 65535));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
